// File: rtl/memory_arbiter_pkg.sv
// Shared types and widths for the host/CPU memory arbiter.
// Holds the FSM state encoding and the RAM address, data and cycle-counter widths.
package memory_arbiter_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 24;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // 2'b11 is deliberately left unnamed; the FSM recovers from it to ST_LOAD.
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } arb_state_t;

  function automatic logic host_owns_ram(input arb_state_t s);
    return (s == ST_LOAD) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/memory_arbiter_cpu_tick_edge.sv
// Detects falling edges of the divided CPU clock, which is sampled as data.
// FALL is high for the single MAIN_CLOCK cycle in which CPU_CLOCK is first seen low.
module cpu_tick_edge (
  input  logic MAIN_CLOCK,
  input  logic RESET,
  input  logic CPU_CLOCK,
  output logic FALL
);

  logic cpu_clock_q;

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      cpu_clock_q <= 1'b0;
    end else begin
      cpu_clock_q <= CPU_CLOCK;
    end
  end

  assign FALL = cpu_clock_q & ~CPU_CLOCK;

endmodule

// File: rtl/memory_arbiter.sv
// Arbitrates a single-port synchronous RAM between a host loader and a CPU.
// The host owns the RAM in LOAD/DONE; the CPU owns it in RUN, bounded by a timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter cnt_t RUN_TIMEOUT = 24'd1000000
) (
  input  logic              MAIN_CLOCK,
  input  logic              RESET,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [DATA_W-1:0] HOST_WDATA,
  input  logic              HOST_GO,
  output logic              HOST_GNT,
  output logic [DATA_W-1:0] HOST_RDATA,
  output logic              HOST_RVALID,
  input  logic              CPU_CLOCK,
  input  logic [ADDR_W-1:0] CPU_ADDRESS,
  input  logic [DATA_W-1:0] CPU_DATA,
  input  logic              CPU_WRITE_EN,
  input  logic              PROCESS_FINISHED,
  output logic              START_PROCESSING_FLAG,
  output logic [DATA_W-1:0] DATA_FROM_RAM,
  output logic [ADDR_W-1:0] RAM_ADDR,
  output logic [DATA_W-1:0] RAM_WDATA,
  output logic              RAM_WE,
  input  logic [DATA_W-1:0] RAM_RDATA,
  output logic [1:0]        STATE,
  output logic              TIMED_OUT,
  output logic [CNT_W-1:0]  CYCLE_COUNT
);

  arb_state_t state_q, state_d;
  cnt_t       count_q, count_d;
  logic       timed_out_q, timed_out_d;
  logic       rd_pending_q;
  logic       cpu_fall;
  logic       host_accept;

  cpu_tick_edge u_cpu_tick_edge (
    .MAIN_CLOCK (MAIN_CLOCK),
    .RESET      (RESET),
    .CPU_CLOCK  (CPU_CLOCK),
    .FALL       (cpu_fall)
  );

  always_ff @(posedge MAIN_CLOCK) begin
    if (RESET) begin
      state_q      <= ST_LOAD;
      count_q      <= '0;
      timed_out_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      timed_out_q  <= timed_out_d;
      rd_pending_q <= host_accept & ~HOST_WE;
    end
  end

  // Counter advances in every RUN cycle, including the one that leaves RUN,
  // so it reads as the number of RUN cycles once DONE is reached.
  always_comb begin
    state_d     = ST_LOAD;
    count_d     = count_q;
    timed_out_d = timed_out_q;
    case (state_q)
      ST_LOAD: begin
        state_d = ST_LOAD;
        if (HOST_GO) begin
          state_d     = ST_RUN;
          count_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      ST_RUN: begin
        state_d = ST_RUN;
        count_d = count_q + cnt_t'(1);
        if (PROCESS_FINISHED) begin
          state_d = ST_DONE;
        end else if (count_q == RUN_TIMEOUT - cnt_t'(1)) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  assign HOST_GNT    = host_owns_ram(state_q);
  assign host_accept = HOST_REQ & HOST_GNT;

  always_comb begin
    RAM_ADDR      = '0;
    RAM_WDATA     = '0;
    RAM_WE        = 1'b0;
    DATA_FROM_RAM = '0;
    case (state_q)
      ST_RUN: begin
        RAM_ADDR      = CPU_ADDRESS;
        RAM_WDATA     = CPU_DATA;
        RAM_WE        = cpu_fall & CPU_WRITE_EN;
        DATA_FROM_RAM = RAM_RDATA;
      end
      ST_LOAD, ST_DONE: begin
        RAM_ADDR  = HOST_ADDR;
        RAM_WDATA = HOST_WDATA;
        RAM_WE    = host_accept & HOST_WE;
      end
      default: begin
      end
    endcase
  end

  // Read data is taken straight from the RAM; the pending flag alone marks it valid.
  assign HOST_RVALID           = rd_pending_q;
  assign HOST_RDATA            = rd_pending_q ? RAM_RDATA : '0;
  assign START_PROCESSING_FLAG = (state_q == ST_RUN);
  assign STATE                 = state_q;
  assign TIMED_OUT             = timed_out_q;
  assign CYCLE_COUNT           = count_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench: two arbiters (default and 16-cycle timeout) share one stimulus,
// each with its own RAM; a behavioural model checks every cycle, plus literal spot checks.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst, host_req, host_we, host_go, cpu_clock, cpu_we, pf;
  logic [15:0] host_addr, cpu_addr;
  logic [7:0]  host_wdata, cpu_data;

  logic        gnt       [2];
  logic [7:0]  rdata     [2];
  logic        rvalid    [2];
  logic        start     [2];
  logic [7:0]  dfr       [2];
  logic [15:0] ram_addr  [2];
  logic [7:0]  ram_wdata [2];
  logic        ram_we    [2];
  logic [7:0]  ram_rdata [2];
  logic [1:0]  st        [2];
  logic        tmo_o     [2];
  logic [23:0] cc        [2];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  memory_arbiter dut0 (
    .MAIN_CLOCK(clk), .RESET(rst), .HOST_REQ(host_req), .HOST_WE(host_we),
    .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_GO(host_go),
    .HOST_GNT(gnt[0]), .HOST_RDATA(rdata[0]), .HOST_RVALID(rvalid[0]),
    .CPU_CLOCK(cpu_clock), .CPU_ADDRESS(cpu_addr), .CPU_DATA(cpu_data),
    .CPU_WRITE_EN(cpu_we), .PROCESS_FINISHED(pf),
    .START_PROCESSING_FLAG(start[0]), .DATA_FROM_RAM(dfr[0]),
    .RAM_ADDR(ram_addr[0]), .RAM_WDATA(ram_wdata[0]), .RAM_WE(ram_we[0]),
    .RAM_RDATA(ram_rdata[0]), .STATE(st[0]), .TIMED_OUT(tmo_o[0]),
    .CYCLE_COUNT(cc[0])
  );

  memory_arbiter #(.RUN_TIMEOUT(24'd16)) dut1 (
    .MAIN_CLOCK(clk), .RESET(rst), .HOST_REQ(host_req), .HOST_WE(host_we),
    .HOST_ADDR(host_addr), .HOST_WDATA(host_wdata), .HOST_GO(host_go),
    .HOST_GNT(gnt[1]), .HOST_RDATA(rdata[1]), .HOST_RVALID(rvalid[1]),
    .CPU_CLOCK(cpu_clock), .CPU_ADDRESS(cpu_addr), .CPU_DATA(cpu_data),
    .CPU_WRITE_EN(cpu_we), .PROCESS_FINISHED(pf),
    .START_PROCESSING_FLAG(start[1]), .DATA_FROM_RAM(dfr[1]),
    .RAM_ADDR(ram_addr[1]), .RAM_WDATA(ram_wdata[1]), .RAM_WE(ram_we[1]),
    .RAM_RDATA(ram_rdata[1]), .STATE(st[1]), .TIMED_OUT(tmo_o[1]),
    .CYCLE_COUNT(cc[1])
  );

  // External single-port synchronous RAMs (read-before-write).
  logic [7:0] ram [2][65536];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (ram_we[k]) ram[k][ram_addr[k]] <= ram_wdata[k];
      ram_rdata[k] <= ram[k][ram_addr[k]];
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s[dut%0d]: got %0h expected %0h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=LOAD 1=RUN 2=DONE; memory image per instance.
  int         tmo  [2] = '{1000000, 16};
  int         m_st [2];
  int         m_cnt[2];
  bit         m_to [2];
  bit         m_pend[2];
  bit         m_prev[2];
  logic [7:0] m_rd [2];
  logic [7:0] m_mem[2][65536];
  bit         m_valid = 1'b0;

  bit          run;
  logic        e_we;
  logic [15:0] e_addr;
  logic [7:0]  e_wd;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      run    = (m_st[k] == 1);
      e_we   = run ? (m_prev[k] & ~cpu_clock & cpu_we) : (host_req & host_we);
      e_addr = run ? cpu_addr : host_addr;
      e_wd   = run ? cpu_data : host_wdata;
      if (m_valid) begin
        chk("state",       k, st[k],     m_st[k]);
        chk("gnt",         k, gnt[k],    !run);
        chk("start",       k, start[k],  run);
        chk("timed_out",   k, tmo_o[k],  m_to[k]);
        chk("cycle_count", k, cc[k],     m_cnt[k]);
        chk("rvalid",      k, rvalid[k], m_pend[k]);
        chk("rdata",       k, rdata[k],  m_pend[k] ? m_rd[k] : 8'h00);
        chk("ram_we",      k, ram_we[k], e_we);
        chk("ram_addr",    k, ram_addr[k], e_addr);
        if (e_we) chk("ram_wdata", k, ram_wdata[k], e_wd);
        chk("data_from_ram", k, dfr[k], run ? m_rd[k] : 8'h00);
      end
      m_rd[k] = m_mem[k][e_addr];
      if (e_we) m_mem[k][e_addr] = e_wd;
      if (rst) begin
        m_st[k] = 0; m_cnt[k] = 0; m_to[k] = 0; m_pend[k] = 0; m_prev[k] = 0;
      end else begin
        m_pend[k] = host_req & !run & ~host_we;
        m_prev[k] = cpu_clock;
        case (m_st[k])
          0: if (host_go) begin m_st[k] = 1; m_cnt[k] = 0; m_to[k] = 0; end
          1: begin
            if (pf) m_st[k] = 2;
            else if (m_cnt[k] == tmo[k] - 1) begin m_st[k] = 2; m_to[k] = 1; end
            m_cnt[k]++;
          end
          default: ;
        endcase
      end
    end
    if (rst) m_valid = 1'b1;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_go = 0;
    cpu_clock = 0; cpu_addr = 0; cpu_data = 0; cpu_we = 0; pf = 0;
    cyc(2);
    rst = 0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_state", k, st[k], 0);
      chk("rst_cc", k, cc[k], 0);
      chk("rst_gnt", k, gnt[k], 1);
      chk("rst_rvalid", k, rvalid[k], 0);
      chk("rst_start", k, start[k], 0);
    end

    // Host load and back-to-back readback.
    host_req = 1; host_we = 1; host_addr = 16'h0010; host_wdata = 8'hA5; cyc(1);
    host_addr = 16'h0011; host_wdata = 8'h5A; cyc(1);
    host_we = 0; host_addr = 16'h0010; cyc(1);
    for (int k = 0; k < 2; k++) begin
      chk("rb_rvalid", k, rvalid[k], 1);
      chk("rb_rdata", k, rdata[k], 8'hA5);
    end
    host_addr = 16'h0011; cyc(1);
    for (int k = 0; k < 2; k++) chk("rb2_rdata", k, rdata[k], 8'h5A);
    host_req = 0; cyc(1);
    for (int k = 0; k < 2; k++) chk("rb_end_rvalid", k, rvalid[k], 0);

    // GO with a read accepted in the same cycle; host held off during RUN.
    host_req = 1; host_we = 0; host_addr = 16'h0010; host_go = 1; cyc(1);
    host_go = 0; host_we = 1; host_wdata = 8'hFF;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("go_state", k, st[k], 1);
      chk("go_start", k, start[k], 1);
      chk("go_gnt", k, gnt[k], 0);
      chk("go_rvalid", k, rvalid[k], 1);
      chk("go_rdata", k, rdata[k], 8'hA5);
      chk("go_ram_we", k, ram_we[k], 0);
    end
    cyc(3);
    for (int k = 0; k < 2; k++) chk("run_host_rvalid", k, rvalid[k], 0);
    host_req = 0;

    // CPU write on a falling CPU_CLOCK edge.
    cpu_addr = 16'h0020; cpu_data = 8'h3C; cpu_we = 1; cpu_clock = 1; cyc(1);
    cpu_clock = 0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("cpu_we", k, ram_we[k], 1);
      chk("cpu_addr", k, ram_addr[k], 16'h0020);
      chk("cpu_wdata", k, ram_wdata[k], 8'h3C);
    end
    cyc(1);
    for (int k = 0; k < 2; k++) chk("cpu_we_single", k, ram_we[k], 0);
    for (int i = 0; i < 8; i++) begin
      cpu_addr = 16'h0030 + 16'(i); cpu_data = 8'(i * 17); cpu_we = (i % 2 == 0);
      cpu_clock = 1; cyc(1);
      cpu_clock = 0; cyc(1);
    end
    cpu_we = 0;

    // Finish after 50 RUN cycles; the 16-cycle instance has already timed out.
    for (int i = 0; i < 200 && cc[0] != 24'd49; i++) cyc(1);
    chk("wait_cc49", 0, cc[0], 49);
    pf = 1; cyc(1); pf = 0;
    chk("fin_state", 0, st[0], 2);
    chk("fin_start", 0, start[0], 0);
    chk("fin_cc", 0, cc[0], 50);
    chk("fin_to", 0, tmo_o[0], 0);
    chk("tmo_state", 1, st[1], 2);
    chk("tmo_cc", 1, cc[1], 16);
    chk("tmo_to", 1, tmo_o[1], 1);

    // Readback in DONE; GO and finish are ignored there.
    host_req = 1; host_we = 0; host_addr = 16'h0020; cyc(1);
    for (int k = 0; k < 2; k++) chk("done_rdata", k, rdata[k], 8'h3C);
    for (int i = 0; i < 4; i++) begin host_addr = 16'h0030 + 16'(i); cyc(1); end
    host_req = 0; cyc(1);
    host_go = 1; pf = 1; cyc(1); host_go = 0; pf = 0;
    for (int k = 0; k < 2; k++) chk("done_hold", k, st[k], 2);
    cyc(1);

    // Reset in the first RUN cycle, with a read accepted in the GO cycle.
    rst = 1; cyc(1); rst = 0;
    host_req = 1; host_we = 0; host_addr = 16'h0010; host_go = 1; cyc(1);
    host_go = 0; host_req = 0;
    for (int k = 0; k < 2; k++) chk("r2_rvalid", k, rvalid[k], 1);
    rst = 1; cyc(1); rst = 0; #1;
    for (int k = 0; k < 2; k++) begin
      chk("mr_state", k, st[k], 0);
      chk("mr_cc", k, cc[k], 0);
      chk("mr_gnt", k, gnt[k], 1);
      chk("mr_rvalid", k, rvalid[k], 0);
      chk("mr_to", k, tmo_o[k], 0);
    end
    host_req = 1; host_we = 0; host_addr = 16'h0011; rst = 1; cyc(1);
    rst = 0; host_req = 0;
    for (int k = 0; k < 2; k++) chk("drop_rvalid", k, rvalid[k], 0);

    // Finish coincident with the timeout cycle: finish wins.
    host_go = 1; cyc(1); host_go = 0;
    for (int i = 0; i < 100 && cc[1] != 24'd15; i++) cyc(1);
    chk("wait_cc15", 1, cc[1], 15);
    pf = 1; cyc(1); pf = 0;
    for (int k = 0; k < 2; k++) begin
      chk("tie_state", k, st[k], 2);
      chk("tie_cc", k, cc[k], 16);
      chk("tie_to", k, tmo_o[k], 0);
    end

    cyc(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
